// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM states, the
// per-stage control bundle, and the canonical control patterns.
package pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_bubble;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_NOP      = 7'b0011001;
  localparam stage_ctrl_t CTRL_FREEZE   = 7'b0000001;
  localparam stage_ctrl_t CTRL_REDIRECT = 7'b1111110;
  localparam stage_ctrl_t CTRL_STALL    = 7'b0001110;
  localparam stage_ctrl_t CTRL_FLOW     = 7'b1100110;

  // A taken branch squashes the stalled ID instruction, so it outranks load-use.
  function automatic stage_ctrl_t run_ctrl(input logic branch, input logic lu);
    if (branch)  return CTRL_REDIRECT;
    else if (lu) return CTRL_STALL;
    else         return CTRL_FLOW;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/memory request inputs and stage-control outputs of pipeline_stall_ctrl.
// Counter outputs exist only when STALL_COUNTERS_EN is defined.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic       pc_write;
  logic       if_write;
  logic       control_select;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       mem_wb_bubble;
  logic       fault;
  logic [1:0] state_o;
`ifdef STALL_COUNTERS_EN
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;

  modport master (
    output pc_write, if_write, control_select, branch_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en,
           mem_wb_bubble, fault, state_o, lu_stall_cnt, flush_cnt, mem_wait_cnt
  );
  modport slave (
    input  pc_write, if_write, control_select, branch_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en,
           mem_wb_bubble, fault, state_o, lu_stall_cnt, flush_cnt, mem_wait_cnt
  );
`else
  modport master (
    output pc_write, if_write, control_select, branch_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en,
           mem_wb_bubble, fault, state_o
  );
  modport slave (
    input  pc_write, if_write, control_select, branch_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en,
           mem_wb_bubble, fault, state_o
  );
`endif
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                    cnt_d = '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns load-use, branch and data-memory handshake requests into per-stage
// enable/flush/bubble controls. STALL_COUNTERS_EN adds saturating stall counters.
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave ctl
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  stage_ctrl_t         ctrl;
  logic                lu;
  logic                mem_stall;

  always_comb begin
    lu         = !ctl.pc_write | !ctl.if_write | !ctl.control_select;
    mem_stall  = ctl.dmem_req & !ctl.dmem_ready;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = CTRL_NOP;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (mem_stall) begin
          ctrl       = CTRL_FREEZE;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          ctrl = run_ctrl(ctl.branch_taken, lu);
        end
      end
      MEM_WAIT: begin
        // Branch/lu are ignored while frozen and re-evaluated on the release cycle.
        if (!ctl.dmem_ready) begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) state_d = FAULT;
          else                                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          ctrl       = run_ctrl(ctl.branch_taken, lu);
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      FAULT: ctrl = CTRL_NOP;
      default: begin
        state_d    = BOOT;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign ctl.pc_en         = ctrl.pc_en;
  assign ctl.if_id_en      = ctrl.if_id_en;
  assign ctl.if_id_flush   = ctrl.if_id_flush;
  assign ctl.id_ex_bubble  = ctrl.id_ex_bubble;
  assign ctl.ex_mem_en     = ctrl.ex_mem_en;
  assign ctl.mem_wb_en     = ctrl.mem_wb_en;
  assign ctl.mem_wb_bubble = ctrl.mem_wb_bubble;
  assign ctl.fault         = (state_q == FAULT);
  assign ctl.state_o       = state_q;

`ifdef STALL_COUNTERS_EN
  // Each control pattern is unique to its decision, so it identifies the event.
  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clock(clock), .reset(reset), .inc(ctrl == CTRL_STALL), .clear(1'b0),
    .count(ctl.lu_stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock(clock), .reset(reset), .inc(ctrl == CTRL_REDIRECT), .clear(1'b0),
    .count(ctl.flush_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_mem_wait_cnt (
    .clock(clock), .reset(reset), .inc(ctrl == CTRL_FREEZE), .clear(1'b0),
    .count(ctl.mem_wait_cnt)
  );
`endif
endmodule
